// File: rtl/fma_check_pkg.sv
// Shared definitions for the FMA vector checker: FSM states, control-bit
// positions and packed-vector field offsets.
package fma_check_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Bit positions inside the control field: {roundmode[1:0], mul, add, negp, negz}
  localparam int unsigned CTRL_NEGZ = 0;
  localparam int unsigned CTRL_NEGP = 1;
  localparam int unsigned CTRL_ADD  = 2;
  localparam int unsigned CTRL_MUL  = 3;
  localparam int unsigned CTRL_RM   = 4;

  // Vector layout, MSB first: {x, y, z, ctrl, rexpected, flagsexpected}
  function automatic int unsigned off_fexp();
    return 0;
  endfunction

  function automatic int unsigned off_rexp(input int unsigned nf);
    return nf;
  endfunction

  function automatic int unsigned off_ctrl(input int unsigned flen, input int unsigned nf);
    return flen + nf;
  endfunction

  function automatic int unsigned off_z(input int unsigned flen, input int unsigned ctrlw,
                                        input int unsigned nf);
    return flen + nf + ctrlw;
  endfunction

  function automatic int unsigned off_y(input int unsigned flen, input int unsigned ctrlw,
                                        input int unsigned nf);
    return 2 * flen + nf + ctrlw;
  endfunction

  function automatic int unsigned off_x(input int unsigned flen, input int unsigned ctrlw,
                                        input int unsigned nf);
    return 3 * flen + nf + ctrlw;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fma_check_delay.sv
// Valid-tagged delay line that carries expected values alongside the DUT
// pipeline; DEPTH of 0 degenerates to a wire.
module fma_check_delay
  import fma_check_pkg::*;
#(
  parameter int unsigned DEPTH = 0,
  parameter int unsigned W     = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic w_unused;
      assign w_unused  = clk ^ reset ^ clr;
      assign out_valid = in_valid;
      assign out_data  = in_data;
    end else begin : g_pipe
      logic         r_v [DEPTH];
      logic [W-1:0] r_d [DEPTH];

      // clr drops every in-flight valid so an aborted run cannot leak into the next one
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int unsigned i = 0; i < DEPTH; i++) begin
            r_v[i] <= 1'b0;
            r_d[i] <= '0;
          end
        end else begin
          r_v[0] <= in_valid && !clr;
          r_d[0] <= in_data;
          for (int unsigned i = 1; i < DEPTH; i++) begin
            r_v[i] <= r_v[i-1] && !clr;
            r_d[i] <= r_d[i-1];
          end
        end
      end

      assign out_valid = r_v[DEPTH-1];
      assign out_data  = r_d[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/fma_vector_checker.sv
// Test-vector sequencer and checker for the FMA datapath: streams vectors
// from memory into the DUT, aligns expectations and records mismatches.
module fma_vector_checker
  import fma_check_pkg::*;
#(
  parameter int unsigned FLEN    = 16,
  parameter int unsigned NF      = 4,
  parameter int unsigned CTRLW   = 8,
  parameter int unsigned LATENCY = 0,
  parameter int unsigned AW      = 14,
  parameter int unsigned VW      = 4 * FLEN + CTRLW + NF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [AW-1:0]   nvec,
  input  logic            checkflags,
  input  logic            stoponerr,
  output logic [AW-1:0]   vaddr,
  input  logic [VW-1:0]   vdata,
  output logic [FLEN-1:0] x,
  output logic [FLEN-1:0] y,
  output logic [FLEN-1:0] z,
  output logic [1:0]      roundmode,
  output logic            mul,
  output logic            add,
  output logic            negp,
  output logic            negz,
  input  logic [FLEN-1:0] result,
  input  logic [NF-1:0]   flags,
  output logic            busy,
  output logic            done,
  output logic [31:0]     errors,
  output logic [AW-1:0]   vectornum,
  output logic            firstfailvalid,
  output logic [AW-1:0]   firstfail,
  output logic [FLEN-1:0] failresult,
  output logic [NF-1:0]   failflags
);

  localparam int unsigned OFF_FEXP = off_fexp();
  localparam int unsigned OFF_REXP = off_rexp(NF);
  localparam int unsigned OFF_CTRL = off_ctrl(FLEN, NF);
  localparam int unsigned OFF_Z    = off_z(FLEN, CTRLW, NF);
  localparam int unsigned OFF_Y    = off_y(FLEN, CTRLW, NF);
  localparam int unsigned OFF_X    = off_x(FLEN, CTRLW, NF);
  localparam int unsigned EW       = FLEN + NF + AW;

  state_t          r_state;
  logic [AW-1:0]   r_nvec;
  logic [AW-1:0]   r_addr;
  logic            r_checkflags;
  logic            r_stoponerr;
  logic            r_abort;
  logic            r_final;
  logic            r_s0_valid;
  logic [EW-1:0]   r_s0_exp;

  logic            w_dl_valid;
  logic [EW-1:0]   w_dl_exp;
  logic [FLEN-1:0] w_dl_rexp;
  logic [NF-1:0]   w_dl_fexp;
  logic [AW-1:0]   w_dl_idx;
  logic [AW-1:0]   w_nvec_m1;
  logic            w_start_acc;
  logic            w_last_issue;
  logic            w_cmp_en;
  logic            w_mismatch;

  generate
    if (CTRLW > 6) begin : g_ctrl_spare
      logic w_unused_ctrl;
      assign w_unused_ctrl = ^vdata[OFF_CTRL+6 +: CTRLW-6];
    end
  endgenerate

  assign vaddr        = r_addr;
  assign w_nvec_m1    = r_nvec - AW'(1);
  assign w_start_acc  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last_issue = (r_addr == w_nvec_m1);

  assign {w_dl_rexp, w_dl_fexp, w_dl_idx} = w_dl_exp;

  // Compares after an abort are in-flight leftovers and must not be counted
  assign w_cmp_en   = w_dl_valid && ((r_state == S_RUN) || (r_state == S_DRAIN)) && !r_abort;
  assign w_mismatch = (result != w_dl_rexp) || (r_checkflags && (flags != w_dl_fexp));

  // Unpack/register stage: one vector per RUN cycle; outputs hold once issue stops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x          <= '0;
      y          <= '0;
      z          <= '0;
      roundmode  <= '0;
      mul        <= 1'b0;
      add        <= 1'b0;
      negp       <= 1'b0;
      negz       <= 1'b0;
      r_s0_valid <= 1'b0;
      r_s0_exp   <= '0;
    end else begin
      r_s0_valid <= (r_state == S_RUN);
      if (r_state == S_RUN) begin
        x         <= vdata[OFF_X +: FLEN];
        y         <= vdata[OFF_Y +: FLEN];
        z         <= vdata[OFF_Z +: FLEN];
        roundmode <= vdata[OFF_CTRL+CTRL_RM +: 2];
        mul       <= vdata[OFF_CTRL+CTRL_MUL];
        add       <= vdata[OFF_CTRL+CTRL_ADD];
        negp      <= vdata[OFF_CTRL+CTRL_NEGP];
        negz      <= vdata[OFF_CTRL+CTRL_NEGZ];
        r_s0_exp  <= {vdata[OFF_REXP +: FLEN], vdata[OFF_FEXP +: NF], r_addr};
      end
    end
  end

  fma_check_delay #(
    .DEPTH (LATENCY),
    .W     (EW)
  ) u_delay (
    .clk       (clk),
    .reset     (reset),
    .clr       (w_start_acc),
    .in_valid  (r_s0_valid),
    .in_data   (r_s0_exp),
    .out_valid (w_dl_valid),
    .out_data  (w_dl_exp)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_nvec         <= '0;
      r_addr         <= '0;
      r_checkflags   <= 1'b0;
      r_stoponerr    <= 1'b0;
      r_abort        <= 1'b0;
      r_final        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      errors         <= '0;
      vectornum      <= '0;
      firstfailvalid <= 1'b0;
      firstfail      <= '0;
      failresult     <= '0;
      failflags      <= '0;
    end else begin
      if (w_cmp_en) begin
        vectornum <= vectornum + AW'(1);
        if (w_mismatch) begin
          errors <= sat_inc(errors);
          if (!firstfailvalid) begin
            firstfailvalid <= 1'b1;
            firstfail      <= w_dl_idx;
            failresult     <= result;
            failflags      <= flags;
          end
          if (r_stoponerr) begin
            r_abort <= 1'b1;
          end
        end
        if (w_dl_idx == w_nvec_m1) begin
          r_final <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_nvec         <= nvec;
            r_checkflags   <= checkflags;
            r_stoponerr    <= stoponerr;
            r_addr         <= '0;
            r_abort        <= 1'b0;
            r_final        <= 1'b0;
            errors         <= '0;
            vectornum      <= '0;
            firstfailvalid <= 1'b0;
            firstfail      <= '0;
            failresult     <= '0;
            failflags      <= '0;
            if (nvec == '0) begin
              r_state <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              r_state <= S_RUN;
              busy    <= 1'b1;
              done    <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (r_abort) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (w_last_issue) begin
            r_state <= S_DRAIN;
          end else begin
            r_addr <= r_addr + AW'(1);
          end
        end
        S_DRAIN: begin
          if (r_abort || r_final) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
